// File: rtl/pipe3_core_p.sv
// Three-stage IF/ID/EX in-order core, 16-bit instructions, XLEN datapath, 8 registers (R0 = 0).
// Latency: an instruction acked in cycle N retires (EX) in cycle N+2; a taken jump/branch costs 2 slots.
// Backpressure: per-cycle imem_ack; a missing ack injects a bubble into ID and holds the PC.
module pipe3_core_p #(
   parameter int          XLEN     = 16,
   parameter int          PC_W     = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   input  logic [2:0]      dbg_sel,
   output logic [XLEN-1:0] dbg_data,
   output logic            retire_valid,
   output logic [PC_W-1:0] retire_pc,
   output logic            halted
);

   localparam int SH_W = $clog2(XLEN);

   // Run state: IDLE is the single cycle after reset in which no fetch is issued.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Instruction class resolved in ID so EX only switches on a small set of kinds.
   typedef enum logic [2:0] {
      K_NOP   = 3'd0,
      K_ALU_R = 3'd1,
      K_ALU_I = 3'd2,
      K_JMP   = 3'd3,
      K_BEQZ  = 3'd4,
      K_BNEZ  = 3'd5,
      K_JR    = 3'd6,
      K_HALT  = 3'd7
   } kind_t;

   // Everything EX needs about one instruction.
   typedef struct packed {
      logic            vld;
      kind_t           kind;
      logic [2:0]      f3;
      logic [2:0]      rd;
      logic [2:0]      rs1;
      logic [2:0]      rs2;
      logic [7:0]      imm;
      logic [PC_W-1:0] pc;
   } ex_t;

   state_t          state;
   state_t          state_nxt;

   logic [PC_W-1:0] pc;
   logic            id_vld;
   logic [15:0]     id_ir;
   logic [PC_W-1:0] id_pc;
   ex_t             id_dec;
   ex_t             ex_q;

   logic [XLEN-1:0] regs [8];

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] rd_val;
   logic [SH_W-1:0] shamt;
   logic            lt_signed;
   logic [XLEN-1:0] imm_sx;
   logic [XLEN-1:0] imm_zx;
   logic [XLEN-1:0] imm_hi;
   logic [PC_W-1:0] br_off;

   logic            wr_en;
   logic [XLEN-1:0] wr_val;
   logic            take;
   logic            halt_ex;
   logic [PC_W-1:0] tgt;
   logic            flush;
   logic            fetch;

   assign imem_req     = (state == ST_RUN);
   assign halted       = (state == ST_HALT);
   assign imem_addr    = pc;
   assign fetch        = imem_req & imem_ack;
   assign retire_valid = ex_q.vld;
   assign retire_pc    = ex_q.pc;
   assign flush        = take | halt_ex;
   assign dbg_data     = (dbg_sel == 3'd0) ? '0 : regs[dbg_sel];

   // Run-state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Run-state transitions: start fetching after reset, stop for good on HALT.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = ST_RUN;
         ST_RUN:  if (halt_ex) state_nxt = ST_HALT;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ID decode: classify the latched word and split out its fields.
   always_comb begin
      id_dec      = '0;
      id_dec.vld  = id_vld;
      id_dec.kind = K_NOP;
      id_dec.f3   = id_ir[13:11];
      id_dec.rd   = id_ir[10:8];
      id_dec.rs1  = id_ir[7:5];
      id_dec.rs2  = id_ir[4:2];
      id_dec.imm  = id_ir[7:0];
      id_dec.pc   = id_pc;
      case (id_ir[15:14])
         2'b00: id_dec.kind = K_ALU_R;
         2'b01: begin
            // f3 = 110/111 are defined as NOPs in the I-type space.
            if (id_ir[13:12] != 2'b11) id_dec.kind = K_ALU_I;
         end
         2'b10: begin
            case (id_ir[13:11])
               3'b000:  id_dec.kind = K_JMP;
               3'b001:  id_dec.kind = K_BEQZ;
               3'b010:  id_dec.kind = K_BNEZ;
               3'b011:  id_dec.kind = K_JR;
               default: id_dec.kind = K_NOP;
            endcase
         end
         default: begin
            if (id_ir[13:11] == 3'b111) id_dec.kind = K_HALT;
         end
      endcase
   end

   // EX operand read straight from the register file; writes land at the end of EX,
   // so an instruction one or two slots behind already sees them without forwarding.
   always_comb begin
      rs1_val   = (ex_q.rs1 == 3'd0) ? '0 : regs[ex_q.rs1];
      rs2_val   = (ex_q.rs2 == 3'd0) ? '0 : regs[ex_q.rs2];
      rd_val    = (ex_q.rd  == 3'd0) ? '0 : regs[ex_q.rd];
      shamt     = rs2_val[SH_W-1:0];
      lt_signed = ($signed(rs1_val) < $signed(rs2_val));
      imm_sx    = {{(XLEN-8){ex_q.imm[7]}}, ex_q.imm};
      imm_zx    = {{(XLEN-8){1'b0}}, ex_q.imm};
      imm_hi    = {ex_q.imm, {(XLEN-8){1'b0}}};
      br_off    = {{(PC_W-8){ex_q.imm[7]}}, ex_q.imm};
   end

   // EX execute: ALU result, write enable, and control-transfer / halt resolution.
   always_comb begin
      wr_en   = 1'b0;
      wr_val  = '0;
      take    = 1'b0;
      halt_ex = 1'b0;
      tgt     = ex_q.pc + br_off;
      if (ex_q.vld) begin
         case (ex_q.kind)
            K_ALU_R: begin
               wr_en = 1'b1;
               case (ex_q.f3)
                  3'b000:  wr_val = rs1_val + rs2_val;
                  3'b001:  wr_val = rs1_val - rs2_val;
                  3'b010:  wr_val = rs1_val & rs2_val;
                  3'b011:  wr_val = rs1_val | rs2_val;
                  3'b100:  wr_val = rs1_val ^ rs2_val;
                  3'b101:  wr_val = rs1_val << shamt;
                  3'b110:  wr_val = rs1_val >> shamt;
                  default: wr_val = XLEN'(lt_signed);
               endcase
            end
            K_ALU_I: begin
               wr_en = 1'b1;
               case (ex_q.f3)
                  3'b000:  wr_val = rd_val + imm_sx;
                  3'b001:  wr_val = imm_hi;
                  3'b010:  wr_val = rd_val & imm_zx;
                  3'b011:  wr_val = rd_val | imm_zx;
                  3'b100:  wr_val = rd_val ^ imm_zx;
                  default: wr_val = imm_zx;
               endcase
            end
            K_JMP:  take = 1'b1;
            K_BEQZ: take = (rd_val == '0);
            K_BNEZ: take = (rd_val != '0);
            K_JR: begin
               take = 1'b1;
               tgt  = PC_W'(rd_val);
            end
            K_HALT:  halt_ex = 1'b1;
            default: ;
         endcase
      end
   end

   // IF/ID: fetch on ack, bubble otherwise; a redirect or halt in EX drops whatever is being acked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= PC_W'(RESET_PC);
         id_vld <= 1'b0;
         id_ir  <= '0;
         id_pc  <= '0;
      end else if (flush) begin
         id_vld <= 1'b0;
         if (take) pc <= tgt;
      end else if (fetch) begin
         id_vld <= 1'b1;
         id_ir  <= imem_rdata;
         id_pc  <= pc;
         pc     <= pc + PC_W'(1);
      end else begin
         id_vld <= 1'b0;
      end
   end

   // ID/EX register: the instruction in ID is squashed when EX redirects or halts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= id_dec;
         if (flush) ex_q.vld <= 1'b0;
      end
   end

   // Register file write at the end of EX; R0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (wr_en && (ex_q.rd != 3'd0)) begin
         regs[ex_q.rd] <= wr_val;
      end
   end

endmodule

// File: tb/tb_pipe3_core_p.sv
module tb_pipe3_core_p;

   localparam logic [15:0] INS_NOP  = 16'h7000;
   localparam logic [15:0] INS_HALT = 16'hF800;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // XLEN=16 instance
   logic        rst16 = 1'b1;
   logic        ack_en16 = 1'b1;
   logic        req16, ack16, rv16, halt16;
   logic [15:0] addr16, rdata16, rpc16, data16;
   logic [2:0]  sel16 = 3'd0;
   logic [15:0] mem16 [64];

   assign ack16   = ack_en16 & req16;
   assign rdata16 = mem16[addr16[5:0]];

   pipe3_core_p #(.XLEN(16), .PC_W(16), .RESET_PC(0)) dut16 (
      .clk(clk), .rst(rst16),
      .imem_req(req16), .imem_addr(addr16), .imem_ack(ack16), .imem_rdata(rdata16),
      .dbg_sel(sel16), .dbg_data(data16),
      .retire_valid(rv16), .retire_pc(rpc16), .halted(halt16)
   );

   // XLEN=32 instance
   logic        rst32 = 1'b1;
   logic        req32, ack32, rv32, halt32;
   logic [15:0] addr32, rdata32, rpc32;
   logic [31:0] data32;
   logic [2:0]  sel32 = 3'd0;
   logic [15:0] mem32 [64];

   assign ack32   = req32;
   assign rdata32 = mem32[addr32[5:0]];

   pipe3_core_p #(.XLEN(32), .PC_W(16), .RESET_PC(0)) dut32 (
      .clk(clk), .rst(rst32),
      .imem_req(req32), .imem_addr(addr32), .imem_ack(ack32), .imem_rdata(rdata32),
      .dbg_sel(sel32), .dbg_data(data32),
      .retire_valid(rv32), .retire_pc(rpc32), .halted(halt32)
   );

   int n_pass = 0;
   int n_tot  = 0;
   int rel_cyc;
   int ack_q[$], ackaddr_q[$], rpc_q[$], rcyc_q[$], exp_q[$];

   // Event log for dut16, sampled mid-cycle
   always @(negedge clk) begin
      #2;
      if (!rst16) begin
         if (req16 && ack16) begin
            ack_q.push_back(cyc);
            ackaddr_q.push_back(int'(addr16));
         end
         if (rv16) begin
            rpc_q.push_back(int'(rpc16));
            rcyc_q.push_back(cyc);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] enc_r(input logic [2:0] f3, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
      return {2'b00, f3, rd, rs1, rs2, 2'b00};
   endfunction
   function automatic logic [15:0] enc_i(input logic [2:0] f3, input logic [2:0] rd, input logic [7:0] imm);
      return {2'b01, f3, rd, imm};
   endfunction
   function automatic logic [15:0] enc_c(input logic [2:0] f3, input logic [2:0] rd, input logic [7:0] imm);
      return {2'b10, f3, rd, imm};
   endfunction

   task automatic clear16();
      for (int i = 0; i < 64; i++) mem16[i] = INS_NOP;
   endtask

   task automatic reset16();
      rst16 = 1'b1;
      ack_en16 = 1'b1;
      repeat (2) @(negedge clk);
      ack_q.delete(); ackaddr_q.delete(); rpc_q.delete(); rcyc_q.delete();
      rst16 = 1'b0;
      rel_cyc = cyc;
   endtask

   task automatic run_halt16(input string name, input int max);
      int k = 0;
      while (halt16 !== 1'b1 && k < max) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_halted"}, halt16, 1);
      @(negedge clk);
      #3;
   endtask

   task automatic chk_reg16(input string name, input logic [2:0] r, input logic [15:0] exp);
      @(negedge clk);
      sel16 = r;
      #1;
      chk(name, data16, exp);
   endtask

   task automatic chk_reg32(input string name, input logic [2:0] r, input logic [31:0] exp);
      @(negedge clk);
      sel32 = r;
      #1;
      chk(name, data32, exp);
   endtask

   task automatic chk_ret(input string name, input bit prefix_only);
      if (!prefix_only) chk({name, "_ret_cnt"}, rpc_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rpc_q.size()) chk($sformatf("%s_ret_pc%0d", name, i), rpc_q[i], exp_q[i]);
         else chk($sformatf("%s_ret_missing%0d", name, i), 0, 1);
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] ins;
      logic [2:0]  rd;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[20];

   initial begin
      // ALU / decode vectors; setup is R1=0x005A, R2=0x8000, R3=0x0003
      tbl[0]  = '{"add",     enc_r(3'b000, 3'd4, 3'd1, 3'd3), 3'd4, 16'h005D};
      tbl[1]  = '{"sub",     enc_r(3'b001, 3'd4, 3'd3, 3'd1), 3'd4, 16'hFFA9};
      tbl[2]  = '{"and",     enc_r(3'b010, 3'd4, 3'd1, 3'd3), 3'd4, 16'h0002};
      tbl[3]  = '{"or",      enc_r(3'b011, 3'd4, 3'd1, 3'd3), 3'd4, 16'h005B};
      tbl[4]  = '{"xor",     enc_r(3'b100, 3'd4, 3'd1, 3'd3), 3'd4, 16'h0059};
      tbl[5]  = '{"shl",     enc_r(3'b101, 3'd4, 3'd1, 3'd3), 3'd4, 16'h02D0};
      tbl[6]  = '{"shr",     enc_r(3'b110, 3'd4, 3'd2, 3'd3), 3'd4, 16'h1000};
      tbl[7]  = '{"slt_t",   enc_r(3'b111, 3'd4, 3'd2, 3'd1), 3'd4, 16'h0001};
      tbl[8]  = '{"slt_f",   enc_r(3'b111, 3'd4, 3'd1, 3'd2), 3'd4, 16'h0000};
      tbl[9]  = '{"shl_msk", enc_r(3'b101, 3'd4, 3'd1, 3'd2), 3'd4, 16'h005A};
      tbl[10] = '{"addi",    enc_i(3'b000, 3'd1, 8'hFF),      3'd1, 16'h0059};
      tbl[11] = '{"andi",    enc_i(3'b010, 3'd1, 8'h0F),      3'd1, 16'h000A};
      tbl[12] = '{"ori",     enc_i(3'b011, 3'd1, 8'hF0),      3'd1, 16'h00FA};
      tbl[13] = '{"xori",    enc_i(3'b100, 3'd1, 8'hFF),      3'd1, 16'h00A5};
      tbl[14] = '{"lui",     enc_i(3'b001, 3'd4, 8'h12),      3'd4, 16'h1200};
      tbl[15] = '{"inop6",   enc_i(3'b110, 3'd1, 8'h33),      3'd1, 16'h005A};
      tbl[16] = '{"inop7",   enc_i(3'b111, 3'd1, 8'h33),      3'd1, 16'h005A};
      tbl[17] = '{"cnop",    enc_c(3'b100, 3'd1, 8'h00),      3'd1, 16'h005A};
      tbl[18] = '{"snop",    {2'b11, 3'b000, 3'd1, 8'h00},    3'd1, 16'h005A};
      tbl[19] = '{"beqz_nt", enc_c(3'b001, 3'd1, 8'h00),      3'd1, 16'h005A};

      clear16();
      for (int i = 0; i < 64; i++) mem32[i] = INS_NOP;

      // Reset state
      #12;
      chk("rst_req", req16, 0);
      chk("rst_addr", addr16, 0);
      chk("rst_halted", halt16, 0);
      chk("rst_retv", rv16, 0);
      chk("rst_retpc", rpc16, 0);
      sel16 = 3'd3;
      #1;
      chk("rst_reg3", data16, 0);

      // Test 1: straight-line ALU, retire timing
      clear16();
      mem16[0] = enc_i(3'b101, 3'd1, 8'h05);
      mem16[1] = enc_i(3'b101, 3'd2, 8'h03);
      mem16[2] = enc_r(3'b000, 3'd3, 3'd1, 3'd2);
      mem16[3] = enc_r(3'b001, 3'd4, 3'd1, 3'd2);
      mem16[4] = INS_HALT;
      reset16();
      #1;
      chk("t1_req_low_at_release", req16, 0);
      run_halt16("t1", 40);
      exp_q = '{0, 1, 2, 3, 4};
      chk_ret("t1", 1'b0);
      if (ack_q.size() > 0) chk("t1_first_ack_cyc", ack_q[0], rel_cyc + 1);
      else chk("t1_no_ack", 0, 1);
      for (int i = 0; i < 5; i++)
         if (i < rcyc_q.size() && ack_q.size() > 0)
            chk($sformatf("t1_ret_cyc%0d", i), rcyc_q[i], ack_q[0] + 2 + i);
      chk("t1_req_after_halt", req16, 0);
      chk_reg16("t1_r3", 3'd3, 16'h0008);
      chk_reg16("t1_r4", 3'd4, 16'h0002);

      // Test 2: back-to-back dependency and R0 write discard
      clear16();
      mem16[0] = enc_i(3'b101, 3'd1, 8'hFF);
      mem16[1] = enc_i(3'b000, 3'd1, 8'h01);
      mem16[2] = enc_i(3'b101, 3'd0, 8'h12);
      mem16[3] = INS_HALT;
      reset16();
      run_halt16("t2", 40);
      chk_reg16("t2_r1", 3'd1, 16'h0100);
      chk_reg16("t2_r0", 3'd0, 16'h0000);

      // Test 3: backward jump at PC 4, then reset while looping
      clear16();
      mem16[0] = enc_i(3'b101, 3'd1, 8'h01);
      mem16[4] = enc_c(3'b000, 3'd0, 8'hFC);
      mem16[5] = enc_i(3'b101, 3'd6, 8'h77);
      mem16[6] = enc_i(3'b101, 3'd7, 8'h77);
      reset16();
      repeat (16) @(negedge clk);
      #3;
      exp_q = '{0, 1, 2, 3, 4, 0, 1};
      chk_ret("t3", 1'b1);
      if (rcyc_q.size() > 5) chk("t3_flush_gap", rcyc_q[5] - rcyc_q[4], 3);
      else chk("t3_flush_gap_missing", 0, 1);
      if (ackaddr_q.size() > 7 && rcyc_q.size() > 4) begin
         chk("t3_refetch_addr", ackaddr_q[7], 0);
         chk("t3_refetch_cyc", ack_q[7], rcyc_q[4] + 1);
      end else chk("t3_refetch_missing", 0, 1);
      chk_reg16("t3_r6", 3'd6, 16'h0000);
      chk_reg16("t3_r7", 3'd7, 16'h0000);
      chk_reg16("t3_r1", 3'd1, 16'h0001);
      #2;
      rst16 = 1'b1;
      #1;
      chk("t3_mid_rst_addr", addr16, 0);
      chk("t3_mid_rst_retv", rv16, 0);
      chk("t3_mid_rst_req", req16, 0);
      sel16 = 3'd1;
      #1;
      chk("t3_mid_rst_r1", data16, 0);

      // Test 4: taken beqz then not-taken bnez
      clear16();
      mem16[0] = enc_c(3'b001, 3'd5, 8'h03);
      mem16[1] = enc_i(3'b101, 3'd6, 8'h11);
      mem16[2] = enc_i(3'b101, 3'd6, 8'h22);
      mem16[3] = enc_c(3'b010, 3'd5, 8'h03);
      mem16[4] = enc_i(3'b101, 3'd7, 8'h33);
      mem16[5] = INS_HALT;
      reset16();
      run_halt16("t4", 40);
      exp_q = '{0, 3, 4, 5};
      chk_ret("t4", 1'b0);
      if (rcyc_q.size() == 4) begin
         chk("t4_gap_taken", rcyc_q[1] - rcyc_q[0], 3);
         chk("t4_gap_nt", rcyc_q[2] - rcyc_q[1], 1);
      end else chk("t4_cyc_missing", 0, 1);
      chk_reg16("t4_r6", 3'd6, 16'h0000);
      chk_reg16("t4_r7", 3'd7, 16'h0033);

      // Test 5: ack low for 3 cycles after two fetches
      clear16();
      mem16[0] = enc_i(3'b101, 3'd1, 8'h05);
      mem16[1] = enc_i(3'b101, 3'd2, 8'h03);
      mem16[2] = enc_r(3'b000, 3'd3, 3'd1, 3'd2);
      mem16[3] = enc_r(3'b001, 3'd4, 3'd1, 3'd2);
      mem16[4] = INS_HALT;
      reset16();
      repeat (3) @(negedge clk);
      ack_en16 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t5_addr_hold%0d", i), addr16, 2);
         @(negedge clk);
      end
      ack_en16 = 1'b1;
      run_halt16("t5", 40);
      exp_q = '{0, 1, 2, 3, 4};
      chk_ret("t5", 1'b0);
      if (rcyc_q.size() == 5) begin
         chk("t5_ret0_cyc", rcyc_q[0], rel_cyc + 3);
         chk("t5_gap01", rcyc_q[1] - rcyc_q[0], 1);
         chk("t5_gap12", rcyc_q[2] - rcyc_q[1], 4);
         chk("t5_gap23", rcyc_q[3] - rcyc_q[2], 1);
      end else chk("t5_cyc_missing", 0, 1);
      chk_reg16("t5_r3", 3'd3, 16'h0008);
      chk_reg16("t5_r4", 3'd4, 16'h0002);

      // Test 7: jr through a register
      clear16();
      mem16[0] = enc_i(3'b101, 3'd1, 8'h04);
      mem16[1] = enc_c(3'b011, 3'd1, 8'h00);
      mem16[2] = enc_i(3'b101, 3'd6, 8'h66);
      mem16[3] = enc_i(3'b101, 3'd6, 8'h67);
      mem16[4] = enc_i(3'b101, 3'd7, 8'h12);
      mem16[5] = INS_HALT;
      reset16();
      run_halt16("t7", 40);
      exp_q = '{0, 1, 4, 5};
      chk_ret("t7", 1'b0);
      chk_reg16("t7_r6", 3'd6, 16'h0000);
      chk_reg16("t7_r7", 3'd7, 16'h0012);

      // Table: one instruction under test per run, after a fixed setup
      for (int v = 0; v < 20; v++) begin
         clear16();
         mem16[0] = enc_i(3'b101, 3'd1, 8'h5A);
         mem16[1] = enc_i(3'b001, 3'd2, 8'h80);
         mem16[2] = enc_i(3'b101, 3'd3, 8'h03);
         mem16[3] = tbl[v].ins;
         mem16[4] = INS_HALT;
         reset16();
         run_halt16(tbl[v].name, 40);
         chk({tbl[v].name, "_ret_cnt"}, rpc_q.size(), 5);
         chk_reg16(tbl[v].name, tbl[v].rd, tbl[v].exp);
      end

      // Test 6: XLEN=32 lui/slt/HALT, then reset while halted
      mem32[0] = enc_i(3'b001, 3'd1, 8'h80);
      mem32[1] = enc_r(3'b111, 3'd2, 3'd1, 3'd0);
      mem32[2] = INS_HALT;
      mem32[3] = enc_i(3'b101, 3'd3, 8'h55);
      @(negedge clk);
      rst32 = 1'b0;
      for (int k = 0; k < 40 && halt32 !== 1'b1; k++) @(negedge clk);
      chk("t6_halted", halt32, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t6_req_low%0d", i), req32, 0);
      end
      chk_reg32("t6_r1", 3'd1, 32'h8000_0000);
      chk_reg32("t6_r2", 3'd2, 32'h0000_0001);
      chk_reg32("t6_r3", 3'd3, 32'h0000_0000);
      #2;
      rst32 = 1'b1;
      #1;
      chk("t6_rst_halted", halt32, 0);
      chk("t6_rst_addr", addr32, 0);
      chk("t6_rst_req", req32, 0);
      sel32 = 3'd1;
      #1;
      chk("t6_rst_r1", data32, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, checks so far %0d/%0d", n_pass, n_tot);
      $fatal(1);
   end

endmodule
